// File: rtl/sim_periph_pkg.sv
// Shared definitions for the AXI4-Lite simulation peripheral.
// Holds the AXI response codes, the default register offsets, the address
// decode categories and the read/write FSM state encodings.
package sim_periph_pkg;

  // AXI response codes used by this slave
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Default register offsets (compared against addr[13:0])
  localparam logic [13:0] UART_OFFSET_DEF  = 14'h1000;
  localparam logic [13:0] CYCLE_OFFSET_DEF = 14'h1004;

  // Address decode outcome
  typedef enum logic [1:0] {
    DEC_SCRATCH = 2'd0,
    DEC_UART    = 2'd1,
    DEC_CYCLE   = 2'd2,
    DEC_NONE    = 2'd3
  } dec_kind_t;

  // Read channel FSM states
  typedef logic [1:0] rd_state_t;
  localparam rd_state_t R_IDLE = 2'd0;
  localparam rd_state_t R_WAIT = 2'd1;
  localparam rd_state_t R_RESP = 2'd2;

  // Write channel FSM states
  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_COLLECT = 2'd0;
  localparam wr_state_t W_WAIT    = 2'd1;
  localparam wr_state_t W_RESP    = 2'd2;

endpackage

// File: rtl/axi_lite_sim_peripheral_if.sv
// AXI4-Lite bus bundle between the CPU peripheral master and the simulation
// slave. The master modport drives addresses, data, strobes and the
// ready signals of the response channels; the slave modport drives the
// address/data ready signals and the read/write responses.
interface axi_lite_sim_peripheral_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_sim_peripheral_latency.sv
// sim_latency_counter: programmable delay between a start strobe and a
// done indication.
// Ports: clk/rst (sync, active-high); start loads load_val and arms the
// counter; done is high for the single cycle in which the armed count is 0.
// With load_val=N, done is seen N+1 cycles after the start edge.
module sim_latency_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_r;
  logic          busy_r;

  // Load on start, then count down to zero and disarm
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b0;
    end else if (start) begin
      cnt_r  <= load_val;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      if (cnt_r == {CW{1'b0}}) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - CW'(1);
      end
    end
  end

  assign done = busy_r && (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/axi_lite_sim_peripheral.sv
// axi_lite_sim_peripheral: protocol-correct AXI4-Lite slave used inside the
// simulation top level built with Verilator. Maps a scratch register file at
// 0x000, a UART TX register and a free-running 32-bit cycle counter; unmapped
// addresses answer DECERR. Read and write channels are independent FSMs, each
// with its own programmable response latency.
// Ports: clk, rst (sync, active-high); s_axi (AXI4-Lite slave modport);
// write_uart/uart_byte: one-cycle pulse carrying a byte to the C++ harness.
module axi_lite_sim_peripheral
  import sim_periph_pkg::*;
#(
  parameter int          READ_LATENCY  = 5,
  parameter int          WRITE_LATENCY = 5,
  parameter int          SCRATCH_REGS  = 16,
  parameter logic [13:0] UART_OFFSET   = UART_OFFSET_DEF,
  parameter logic [13:0] CYCLE_OFFSET  = CYCLE_OFFSET_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_lite_sim_peripheral_if.slave  s_axi,
  output logic                      write_uart,
  output logic [7:0]                uart_byte
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
  localparam int IW      = (SCRATCH_REGS > 1) ? $clog2(SCRATCH_REGS) : 1;
  localparam logic [13:0]   SCRATCH_LIMIT = 14'(4 * SCRATCH_REGS);
  localparam logic [CW-1:0] RD_LOAD       = CW'(READ_LATENCY);
  localparam logic [CW-1:0] WR_LOAD       = CW'(WRITE_LATENCY);

  // Classify an offset into one of the mapped regions or DECERR
  function automatic dec_kind_t decode(input logic [13:0] a);
    dec_kind_t d;
    if (a < SCRATCH_LIMIT) begin
      d = DEC_SCRATCH;
    end else if (a == UART_OFFSET) begin
      d = DEC_UART;
    end else if (a == CYCLE_OFFSET) begin
      d = DEC_CYCLE;
    end else begin
      d = DEC_NONE;
    end
    return d;
  endfunction

  logic [31:0] scratch_r [SCRATCH_REGS];
  logic [31:0] cycle_r;

  // Read channel state
  rd_state_t   rd_state_r;
  logic [13:0] ar_addr_r;
  logic        arready_r;
  logic        rvalid_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;
  logic        rd_start_s;
  logic        rd_done_s;
  dec_kind_t   rd_dec_s;
  logic [IW-1:0] rd_idx_s;
  logic [31:0] rd_data_s;
  logic [1:0]  rd_resp_s;

  // Write channel state
  wr_state_t   wr_state_r;
  logic [13:0] aw_addr_r;
  logic        aw_got_r;
  logic        w_got_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        awready_r;
  logic        wready_r;
  logic        bvalid_r;
  logic [1:0]  bresp_r;
  logic        write_uart_r;
  logic [7:0]  uart_byte_r;
  logic        aw_hs_s;
  logic        w_hs_s;
  logic        wr_start_s;
  logic        wr_done_s;
  logic        wr_commit_s;
  dec_kind_t   wr_dec_s;
  logic [IW-1:0] wr_idx_s;
  logic [1:0]  wr_resp_s;

  // Only addr[13:0] takes part in decode
  logic unused_addr_s;
  assign unused_addr_s = ^{s_axi.araddr[31:14], s_axi.awaddr[31:14]};

  assign rd_start_s = (rd_state_r == R_IDLE) && s_axi.arvalid && arready_r;
  assign rd_dec_s   = decode(ar_addr_r);
  assign rd_idx_s   = ar_addr_r[2 +: IW];

  assign aw_hs_s     = (wr_state_r == W_COLLECT) && s_axi.awvalid && awready_r;
  assign w_hs_s      = (wr_state_r == W_COLLECT) && s_axi.wvalid && wready_r;
  // Both halves present, counting a handshake happening on this very edge
  assign wr_start_s  = (wr_state_r == W_COLLECT) && (aw_got_r || aw_hs_s) && (w_got_r || w_hs_s);
  assign wr_commit_s = (wr_state_r == W_WAIT) && wr_done_s;
  assign wr_dec_s    = decode(aw_addr_r);
  assign wr_idx_s    = aw_addr_r[2 +: IW];
  assign wr_resp_s   = (wr_dec_s == DEC_NONE) ? RESP_DECERR : RESP_OKAY;

  sim_latency_counter #(.CW(CW)) u_rd_lat (
    .clk      (clk),
    .rst      (rst),
    .start    (rd_start_s),
    .load_val (RD_LOAD),
    .done     (rd_done_s)
  );

  sim_latency_counter #(.CW(CW)) u_wr_lat (
    .clk      (clk),
    .rst      (rst),
    .start    (wr_start_s),
    .load_val (WR_LOAD),
    .done     (wr_done_s)
  );

  // Read-side value mux for the latched address
  always_comb begin
    rd_data_s = 32'h0000_0000;
    rd_resp_s = RESP_OKAY;
    case (rd_dec_s)
      DEC_SCRATCH: rd_data_s = scratch_r[rd_idx_s];
      DEC_UART:    rd_data_s = 32'h0000_0000;
      DEC_CYCLE:   rd_data_s = cycle_r;
      default:     rd_resp_s = RESP_DECERR;
    endcase
  end

  // Free-running cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_r <= 32'h0000_0000;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end

  // Read FSM: accept address, wait the programmed latency, hold response
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_r <= R_IDLE;
      ar_addr_r  <= 14'h0000;
      arready_r  <= 1'b1;
      rvalid_r   <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      rresp_r    <= RESP_OKAY;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (rd_start_s) begin
            ar_addr_r  <= s_axi.araddr[13:0];
            arready_r  <= 1'b0;
            rd_state_r <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_done_s) begin
            rdata_r    <= rd_data_s;
            rresp_r    <= rd_resp_s;
            rvalid_r   <= 1'b1;
            rd_state_r <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_axi.rready) begin
            rvalid_r   <= 1'b0;
            arready_r  <= 1'b1;
            rd_state_r <= R_IDLE;
          end
        end
        default: begin
          rvalid_r   <= 1'b0;
          arready_r  <= 1'b1;
          rd_state_r <= R_IDLE;
        end
      endcase
    end
  end

  // Write FSM: collect AW and W in any order, wait, commit, respond
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r   <= W_COLLECT;
      aw_addr_r    <= 14'h0000;
      aw_got_r     <= 1'b0;
      w_got_r      <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      wstrb_r      <= 4'h0;
      awready_r    <= 1'b1;
      wready_r     <= 1'b1;
      bvalid_r     <= 1'b0;
      bresp_r      <= RESP_OKAY;
      write_uart_r <= 1'b0;
      uart_byte_r  <= 8'h00;
    end else begin
      write_uart_r <= 1'b0;
      case (wr_state_r)
        W_COLLECT: begin
          if (aw_hs_s) begin
            aw_addr_r <= s_axi.awaddr[13:0];
            aw_got_r  <= 1'b1;
            awready_r <= 1'b0;
          end
          if (w_hs_s) begin
            wdata_r  <= s_axi.wdata;
            wstrb_r  <= s_axi.wstrb;
            w_got_r  <= 1'b1;
            wready_r <= 1'b0;
          end
          if (wr_start_s) begin
            wr_state_r <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wr_done_s) begin
            bresp_r    <= wr_resp_s;
            bvalid_r   <= 1'b1;
            wr_state_r <= W_RESP;
            if ((wr_dec_s == DEC_UART) && wstrb_r[0]) begin
              write_uart_r <= 1'b1;
              uart_byte_r  <= wdata_r[7:0];
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_r   <= 1'b0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
            aw_got_r   <= 1'b0;
            w_got_r    <= 1'b0;
            wr_state_r <= W_COLLECT;
          end
        end
        default: begin
          bvalid_r   <= 1'b0;
          awready_r  <= 1'b1;
          wready_r   <= 1'b1;
          aw_got_r   <= 1'b0;
          w_got_r    <= 1'b0;
          wr_state_r <= W_COLLECT;
        end
      endcase
    end
  end

  // Scratch register file with byte-lane writes at commit time
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SCRATCH_REGS; i++) begin
        scratch_r[i] <= 32'h0000_0000;
      end
    end else if (wr_commit_s && (wr_dec_s == DEC_SCRATCH)) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_r[b]) begin
          scratch_r[wr_idx_s][8*b +: 8] <= wdata_r[8*b +: 8];
        end
      end
    end
  end

  assign s_axi.arready = arready_r;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rdata   = rdata_r;
  assign s_axi.rresp   = rresp_r;
  assign s_axi.awready = awready_r;
  assign s_axi.wready  = wready_r;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.bresp   = bresp_r;
  assign write_uart    = write_uart_r;
  assign uart_byte     = uart_byte_r;

endmodule
